// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter between icache and dcache for the single memory port
module mem_arb #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_data,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ack,
    output logic [LINE_W-1:0] dc_data,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [LINE_W-1:0] m_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state;
    logic   grant;
    logic   last;
    logic   pick_dc;
    // dcache wins when it is alone or when icache was served last
    always_comb pick_dc = dc_req && (!ic_req || !last);
    // arbitration FSM with registered memory and client outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 1'b0;
            last    <= 1'b0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            ic_ack  <= 1'b0;
            dc_ack  <= 1'b0;
            ic_data <= '0;
            dc_data <= '0;
        end else begin
            case (state)
                IDLE: if (ic_req || dc_req) begin
                    grant   <= pick_dc;
                    m_req   <= 1'b1;
                    m_we    <= pick_dc && dc_we;
                    m_addr  <= pick_dc ? dc_addr : ic_addr;
                    m_wdata <= pick_dc ? dc_wdata : '0;
                    state   <= BUSY;
                end
                BUSY: if (m_ack) begin
                    m_req <= 1'b0;
                    last  <= grant;
                    state <= RESP;
                    if (grant) begin
                        dc_ack <= 1'b1;
                        if (!m_we) dc_data <= m_rdata;
                    end else begin
                        ic_ack  <= 1'b1;
                        ic_data <= m_rdata;
                    end
                end
                RESP: begin
                    ic_ack <= 1'b0;
                    dc_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
